// File: rtl/uart_tx_if.sv
// Handshake between the TX FIFO head and the UART transmitter.
// The FIFO is the master: it offers a byte, and the transmitter pulses ready to pop it.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and shifts them out as frames on TXD.
// Bit period is {DLH,DLL} * (13 or 16) clocks; the frame format is latched when a byte is accepted.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_if.slave              fifo,
    input  logic [DATA_WIDTH-1:0] mdr_i,
    input  logic [DATA_WIDTH-1:0] dll_i,
    input  logic [DATA_WIDTH-1:0] dlh_i,
    input  logic [DATA_WIDTH-1:0] lcr_i,
    output logic                  txd_o,
    output logic                  tx_busy_o,
    output logic                  tx_done_o
);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_w, div_q, div_d, presc_q, presc_d;
    logic [3:0]            tick_q, tick_d, osr_last_q, osr_last_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, data_mask;
    logic [1:0]            wls_q, wls_d;
    logic                  stb_q, stb_d, pen_q, pen_d, eps_q, eps_d;
    logic                  txd_q, txd_d, done_q, done_d;
    logic                  accept, tick, bit_end, last_data, parity;
    logic                  unused_cfg;

    assign div_w         = {dlh_i, dll_i};
    assign fifo.tx_ready = (state_q == S_IDLE) && (div_w != '0);
    assign accept        = fifo.tx_valid && fifo.tx_ready;
    assign tick          = (presc_q == '0);
    assign bit_end       = tick && (tick_q == osr_last_q);
    assign last_data     = (bit_q == BIT_W'(4 + int'(wls_q)));
    assign unused_cfg    = ^{mdr_i[DATA_WIDTH-1:1], lcr_i[DATA_WIDTH-1:5]};

    // Only the low 5+WLS bits of the latched byte take part in parity.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
        assign data_mask[gi] = (gi < 5 + int'(wls_q));
    end
    assign parity = (^(data_q & data_mask)) ^ ~eps_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            presc_q    <= '0;
            tick_q     <= '0;
            osr_last_q <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            data_q     <= '0;
            wls_q      <= '0;
            stb_q      <= 1'b0;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            osr_last_q <= osr_last_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            data_q     <= data_d;
            wls_q      <= wls_d;
            stb_q      <= stb_d;
            pen_q      <= pen_d;
            eps_q      <= eps_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        presc_d    = presc_q;
        tick_d     = tick_q;
        osr_last_d = osr_last_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        data_d     = data_q;
        wls_d      = wls_q;
        stb_d      = stb_q;
        pen_d      = pen_q;
        eps_d      = eps_q;
        txd_d      = 1'b1;
        done_d     = 1'b0;

        if (state_q == S_IDLE) begin
            if (accept) begin
                state_d    = S_START;
                div_d      = div_w;
                presc_d    = div_w - DIV_WIDTH'(1);
                tick_d     = 4'd0;
                osr_last_d = mdr_i[0] ? 4'd12 : 4'd15;
                bit_d      = '0;
                stop_d     = 1'b0;
                data_d     = fifo.tx_data;
                wls_d      = lcr_i[1:0];
                stb_d      = lcr_i[2];
                pen_d      = lcr_i[3];
                eps_d      = lcr_i[4];
            end
        end else begin
            if (tick) begin
                presc_d = div_q - DIV_WIDTH'(1);
                tick_d  = bit_end ? 4'd0 : tick_q + 4'd1;
            end else begin
                presc_d = presc_q - DIV_WIDTH'(1);
            end
            if (bit_end) begin
                case (state_q)
                    S_START: begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                    S_DATA: begin
                        if (last_data) begin
                            state_d = pen_q ? S_PARITY : S_STOP;
                            stop_d  = 1'b0;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        state_d = S_STOP;
                        stop_d  = 1'b0;
                    end
                    S_STOP: begin
                        if (stop_q == stb_q) state_d = S_IDLE;
                        else                 stop_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // TXD and tx_done are registered, so they are derived from the upcoming state.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = data_d[bit_d];
            S_PARITY: txd_d = parity;
            default:  txd_d = 1'b1;
        endcase
        done_d = (state_d == S_STOP) && (presc_d == '0) &&
                 (tick_d == osr_last_q) && (stop_d == stb_q);
    end

    assign txd_o     = txd_q;
    assign tx_busy_o = (state_q != S_IDLE);
    assign tx_done_o = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, random frames against a frame model,
// and hand-written back-to-back, disabled-divisor and mid-frame reset sequences.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mdr, dll, dlh, lcr;
    logic       txd, tx_busy, tx_done;
    int         checks = 0;
    int         passes = 0;

    uart_tx_if #(.DATA_WIDTH(8)) fifo_if ();

    uart_tx dut (
        .clk       (clk),
        .rst       (rst),
        .fifo      (fifo_if),
        .mdr_i     (mdr),
        .dll_i     (dll),
        .dlh_i     (dlh),
        .lcr_i     (lcr),
        .txd_o     (txd),
        .tx_busy_o (tx_busy),
        .tx_done_o (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [7:0] lcr;
        logic [7:0] mdr;
        logic [15:0] div;
        int         exp_len;
        int         exp_par;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_cfg(input logic [7:0] l, input logic [7:0] m, input logic [15:0] d);
        lcr = l;
        mdr = m;
        dll = d[7:0];
        dlh = d[15:8];
    endtask

    // Sends one byte and checks the full frame against a model built from the frame rules.
    task automatic run_frame(input string name, input logic [7:0] data, input logic [7:0] l,
                             input logic [7:0] m, input logic [15:0] d, input int exp_len,
                             output int par_seen);
        bit   bits[$];
        int   nb, n, len, ones, waited, wave_err, busy_err, ready_err, done_cnt, done_at;
        bit   par;
        nb   = 5 + int'(l[1:0]);
        n    = int'(d) * (m[0] ? 13 : 16);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(data[i]);
            if (data[i]) ones++;
        end
        par = l[4] ? bit'(ones % 2) : bit'(1 - ones % 2);
        if (l[3]) bits.push_back(par);
        bits.push_back(1'b1);
        if (l[2]) bits.push_back(1'b1);
        len = bits.size() * n;

        @(negedge clk);
        set_cfg(l, m, d);
        fifo_if.tx_data  = data;
        fifo_if.tx_valid = 1'b1;
        #1;
        waited = 0;
        while (!fifo_if.tx_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk({name, "_ready_wait"}, int'(fifo_if.tx_ready), 1);
        @(posedge clk);
        #1;
        // Line config and FIFO head change after accept; the frame must not be affected.
        fifo_if.tx_valid = 1'b0;
        fifo_if.tx_data  = 8'($urandom);
        lcr = 8'($urandom);
        mdr = 8'($urandom);

        wave_err = 0; busy_err = 0; ready_err = 0; done_cnt = 0; done_at = -1; par_seen = -1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (txd !== bits[(k - 1) / n]) wave_err++;
            if (tx_busy !== 1'b1) busy_err++;
            if (fifo_if.tx_ready !== 1'b0) ready_err++;
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (l[3] && k == (1 + nb) * n + n / 2) par_seen = int'(txd);
        end
        chk({name, "_wave_errs"}, wave_err, 0);
        chk({name, "_busy_errs"}, busy_err, 0);
        chk({name, "_ready_errs"}, ready_err, 0);
        chk({name, "_done_count"}, done_cnt, 1);
        chk({name, "_done_cycle"}, done_at, (exp_len >= 0) ? exp_len : len);
        @(negedge clk);
        chk({name, "_idle_txd"}, int'(txd), 1);
        chk({name, "_idle_busy"}, int'(tx_busy), 0);
    endtask

    vec_t tbl[4];
    int   par_seen, waited, pitch, idle_cnt, idle_low, bad_ready, bad_txd, bad_busy;
    bit   done_seen;

    initial begin
        tbl[0] = '{"t1_8n1_55", 8'h55, 8'h03, 8'h00, 16'd1, 160, -1};
        tbl[1] = '{"t2_8e1_07", 8'h07, 8'h1B, 8'h01, 16'd2, 286, 1};
        tbl[2] = '{"t3_5o2_ff", 8'hFF, 8'h0C, 8'h00, 16'd1, 144, 0};
        tbl[3] = '{"t_6e1_a5",  8'hA5, 8'h19, 8'h01, 16'd1, 117, 1};

        rst = 1'b1;
        fifo_if.tx_valid = 1'b0;
        fifo_if.tx_data  = 8'h00;
        set_cfg(8'h03, 8'h00, 16'd1);
        repeat (3) @(negedge clk);
        chk("reset_txd", int'(txd), 1);
        chk("reset_busy", int'(tx_busy), 0);
        chk("reset_done", int'(tx_done), 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_frame(tbl[i].name, tbl[i].data, tbl[i].lcr, tbl[i].mdr, tbl[i].div,
                      tbl[i].exp_len, par_seen);
            if (tbl[i].exp_par >= 0) chk({tbl[i].name, "_parity"}, par_seen, tbl[i].exp_par);
            $display("frame %s data=%02h lcr=%02h mdr=%02h div=%0d", tbl[i].name,
                     tbl[i].data, tbl[i].lcr, tbl[i].mdr, tbl[i].div);
        end

        for (int r = 0; r < 8; r++) begin
            logic [7:0]  rd, rl, rm;
            logic [15:0] rv;
            rd = 8'($urandom);
            rl = 8'($urandom_range(0, 31));
            rm = 8'($urandom_range(0, 1));
            rv = 16'($urandom_range(1, 3));
            run_frame($sformatf("rand%0d", r), rd, rl, rm, rv, -1, par_seen);
            $display("frame rand%0d data=%02h lcr=%02h mdr=%02h div=%0d", r, rd, rl, rm, rv);
        end

        // Back-to-back: two bytes with valid held high, 8N1, N=16.
        @(negedge clk);
        set_cfg(8'h03, 8'h00, 16'd1);
        fifo_if.tx_data  = 8'hA5;
        fifo_if.tx_valid = 1'b1;
        #1;
        waited = 0;
        while (!fifo_if.tx_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("b2b_first_ready", int'(fifo_if.tx_ready), 1);
        @(posedge clk);
        #1;
        fifo_if.tx_data = 8'h3C;
        pitch = -1; idle_cnt = 0; idle_low = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (!tx_busy) begin
                idle_cnt++;
                if (!txd) idle_low++;
            end
            if (fifo_if.tx_ready && fifo_if.tx_valid) begin
                pitch = k;
                break;
            end
        end
        chk("b2b_pitch", pitch, 161);
        chk("b2b_idle_cycles", idle_cnt, 1);
        chk("b2b_idle_txd_low", idle_low, 0);
        @(posedge clk);
        #1;
        fifo_if.tx_valid = 1'b0;
        done_seen = 1'b0;
        for (int k = 1; k <= 300 && !done_seen; k++) begin
            @(negedge clk);
            if (tx_done) done_seen = 1'b1;
        end
        chk("b2b_second_done", int'(done_seen), 1);
        $display("sequence back_to_back pitch=%0d idle=%0d", pitch, idle_cnt);
        repeat (2) @(negedge clk);

        // Divisor zero: transmitter must stay disabled.
        set_cfg(8'h03, 8'h00, 16'd0);
        fifo_if.tx_data  = 8'h81;
        fifo_if.tx_valid = 1'b1;
        bad_ready = 0; bad_txd = 0; bad_busy = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (fifo_if.tx_ready !== 1'b0) bad_ready++;
            if (txd !== 1'b1) bad_txd++;
            if (tx_busy !== 1'b0) bad_busy++;
        end
        chk("div0_ready_high", bad_ready, 0);
        chk("div0_txd_low", bad_txd, 0);
        chk("div0_busy_high", bad_busy, 0);
        fifo_if.tx_valid = 1'b0;
        $display("sequence div_zero 1000 cycles");

        // Reset in the middle of the data phase aborts the frame at once.
        @(negedge clk);
        set_cfg(8'h03, 8'h00, 16'd1);
        fifo_if.tx_data  = 8'h55;
        fifo_if.tx_valid = 1'b1;
        #1;
        waited = 0;
        while (!fifo_if.tx_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        fifo_if.tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_pre_busy", int'(tx_busy), 1);
        chk("rst_pre_txd", int'(txd), 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_txd_same_cycle", int'(txd), 1);
        chk("rst_busy_same_cycle", int'(tx_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        run_frame("rst_resend", 8'h55, 8'h03, 8'h00, 16'd1, 160, par_seen);
        $display("sequence reset_mid_frame resend done");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
